ab_input_conditioner: RTL and testbench
=======================================

# ab_input_conditioner

Upstream conditioning stage for the two-input sequential design: takes raw, asynchronous, possibly bouncing `a`/`b` levels and delivers clean, clock-synchronous levels plus one-cycle edge strobes. Its `a_out`/`b_out` drive the sequential design's `a_in`/`b_in` directly. Each channel has a two-flop synchronizer followed by a consecutive-cycle stability filter. Both channels are identical and fully independent.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive clock edges a synchronized mismatch must persist before the output changes. Legal values are 1 to 255; any value outside this range is an elaboration error.
- `CNT_W`, localparam, `$clog2(STABLE_CYCLES+1)`: width of each stability counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `a_raw_in`, in, 1: raw asynchronous level for channel a.
- `b_raw_in`, in, 1: raw asynchronous level for channel b.
- `a_out`, out, 1: filtered level for channel a.
- `b_out`, out, 1: filtered level for channel b.
- `a_rise_out`, out, 1: one-cycle strobe when `a_out` goes 0→1.
- `a_fall_out`, out, 1: one-cycle strobe when `a_out` goes 1→0.
- `b_rise_out`, out, 1: one-cycle strobe when `b_out` goes 0→1.
- `b_fall_out`, out, 1: one-cycle strobe when `b_out` goes 1→0.
- `any_change_out`, out, 1: OR of the four strobes, registered in the same edge as the strobes.

## Operation

Per-channel state: `sync1`, `sync2`, `cnt[CNT_W-1:0]`, `lvl` (drives `x_out`), and the rise/fall registers.

Synchronizer:
- Every edge, `sync1 <= raw` and `sync2 <= sync1`.
- Only `sync2` feeds the filter logic.

Filter, evaluated every edge:
- **Match** (`sync2 == lvl`): `cnt <= 0`. Level and strobes are unchanged except that strobes clear.
- **Mismatch, not yet stable** (`sync2 != lvl` and `cnt < STABLE_CYCLES-1`): `cnt <= cnt+1`.
- **Mismatch, stable** (`sync2 != lvl` and `cnt == STABLE_CYCLES-1`): `lvl <= sync2`, `cnt <= 0`, and assert `rise` if `sync2 == 1` or `fall` if `sync2 == 0`.

Strobes:
- Rise and fall strobes are high for exactly one cycle and are never both high on the same channel.
- `any_change_out` is high on any edge where at least one channel's strobe is set.
- Both channels can flip on the same edge. `any_change_out` is still a single one-cycle pulse in that case.

Glitches:
- Any return to match before the count completes resets `cnt` to 0.
- A mismatch run shorter than `STABLE_CYCLES` edges produces no output change and no strobe.

Counter width:
- `cnt` never exceeds `STABLE_CYCLES-1` and never wraps.

Reset:
- On an edge with `reset=1`, all state is forced to 0: `sync1`, `sync2`, `cnt`, `lvl`, and all strobes.
- All outputs read 0 after that edge.
- Reset overrides any filter transition scheduled for the same edge.
- Reset asserted mid-count discards the partial count.
- A raw input held at 1 through reset re-qualifies from scratch after reset is released.

## Timing

Latency:
- Raw input first sampled at edge 0 and held stable: `x_out` changes at edge `STABLE_CYCLES+1`, and the matching strobe is high for the cycle after that edge.
- With the default 4, the output changes at edge 5. With `STABLE_CYCLES=1`, it changes at edge 2.

Glitch rejection:
- A pulse is rejected if the synchronized mismatch lasts ≤ `STABLE_CYCLES-1` edges.

Reset release:
- After the last reset edge, with raw held at 1, the output follows the same timing as a fresh change sampled at the first non-reset edge.

Channel independence:
- There is no coupling between channels. A change on a does not affect b's count.

Outputs:
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

All scenarios use the default `STABLE_CYCLES=4` unless stated.

1. **Reset values:** assert `reset` for 2 edges with raws at 1 → every output is 0 after the first reset edge. Release reset → `a_out`/`b_out` = 1 at edge 5 after release, `a_rise_out`, `b_rise_out` and `any_change_out` each high for one cycle.
2. **Glitch reject:** with `a_out`=0, raise `a_raw_in` for 3 edges, then drop it → `a_out` stays 0, no strobes, and the internal `cnt` returns to 0.
3. **Qualified edge:** hold `a_raw_in`=1 from edge 0 → `a_out`=1 at edge 5, `a_rise_out`=1 for exactly one cycle. Drop the raw → `a_out`=0 five edges later with `a_fall_out` pulsed.
4. **Simultaneous channels:** raise `a_raw_in` and `b_raw_in` on the same edge → both outputs rise on the same edge, and `any_change_out` is a single one-cycle pulse.
5. **Reset mid-count:** start an `a` change, assert `reset` at edge 3 for 1 edge while holding raw at 1 → no output change at edge 5. `a_out`=1 at edge 5 after release.
6. **`STABLE_CYCLES=1` build:** hold a raw change → output changes at edge 2. A 1-edge raw pulse still propagates, because one synchronized edge satisfies the filter.

Source files
------------

// File: rtl/ab_input_conditioner.sv
// ab_input_conditioner: two independent raw-level channels, each passed through
// a two-flop synchronizer and a consecutive-edge stability filter, producing a
// clean level plus one-cycle rise/fall strobes and a shared any-change strobe.

module ab_input_conditioner_chan #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic lvl_out,
  output logic rise_out,
  output logic fall_out,
  output logic flip_next
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             lvl;
  logic             rise;
  logic             fall;
  logic             mismatch;
  logic             stable;

  // Qualify the synchronized level against the current output level.
  always_comb begin
    mismatch  = (sync2 != lvl);
    stable    = (cnt == CNT_LAST);
    flip_next = !reset && mismatch && stable;
  end

  // Synchronizer, stability counter, level and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (!mismatch) begin
        cnt <= '0;
      end else if (stable) begin
        lvl  <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= !sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign lvl_out  = lvl;
  assign rise_out = rise;
  assign fall_out = fall;

endmodule

module ab_input_conditioner #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw_in,
  input  logic b_raw_in,
  output logic a_out,
  output logic b_out,
  output logic a_rise_out,
  output logic a_fall_out,
  output logic b_rise_out,
  output logic b_fall_out,
  output logic any_change_out
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
      $error("ab_input_conditioner: STABLE_CYCLES must be in 1..255");
    end
  endgenerate

  logic a_flip_next;
  logic b_flip_next;
  logic any_change;

  ab_input_conditioner_chan #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_a (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (a_raw_in),
    .lvl_out   (a_out),
    .rise_out  (a_rise_out),
    .fall_out  (a_fall_out),
    .flip_next (a_flip_next)
  );

  ab_input_conditioner_chan #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (b_raw_in),
    .lvl_out   (b_out),
    .rise_out  (b_rise_out),
    .fall_out  (b_fall_out),
    .flip_next (b_flip_next)
  );

  // Combined strobe, registered on the same edge the channel strobes are set.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= a_flip_next | b_flip_next;
    end
  end

  assign any_change_out = any_change;

  // Keeps the documented counter-width parameter visible at the top level.
  logic [CNT_W-1:0] cnt_w_unused;
  assign cnt_w_unused = '0;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Bench for ab_input_conditioner: a default build (STABLE_CYCLES=4) and a
// STABLE_CYCLES=1 build share the same stimulus; an edge-indexed model of
// both is compared every cycle, plus directed literal expectations.

module tb_ab_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic a_raw, b_raw;

  logic [6:0] dut_o [2];
  logic a_out0, b_out0, ar0, af0, br0, bf0, any0;
  logic a_out1, b_out1, ar1, af1, br1, bf1, any1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ab_input_conditioner #(.STABLE_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .a_raw_in(a_raw), .b_raw_in(b_raw),
    .a_out(a_out0), .b_out(b_out0), .a_rise_out(ar0), .a_fall_out(af0),
    .b_rise_out(br0), .b_fall_out(bf0), .any_change_out(any0)
  );

  ab_input_conditioner #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .a_raw_in(a_raw), .b_raw_in(b_raw),
    .a_out(a_out1), .b_out(b_out1), .a_rise_out(ar1), .a_fall_out(af1),
    .b_rise_out(br1), .b_fall_out(bf1), .any_change_out(any1)
  );

  assign dut_o[0] = {a_out0, b_out0, ar0, af0, br0, bf0, any0};
  assign dut_o[1] = {a_out1, b_out1, ar1, af1, br1, bf1, any1};

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Filter input at edge k is the raw sampled at edge k-2, forced to 0 if
  // either of the two preceding edges was a reset edge. A channel flips at
  // edge k once S consecutive edges since its last "blocking" edge (reset,
  // agreement with the level, or a flip) have all disagreed with the level.
  int   edge_k = 0;
  bit   model_valid = 0;
  logic r1 [2], r2 [2];
  bit   rst1 = 1, rst2 = 1;
  logic m_lvl  [2][2];
  logic m_rise [2][2];
  logic m_fall [2][2];
  logic m_any  [2];
  int   last_block [2][2];
  logic in_v [2];

  function automatic int s_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      in_v[c] = (rst1 || rst2) ? 1'b0 : r2[c];
    for (int d = 0; d < 2; d++) begin
      m_any[d] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_rise[d][c] = 1'b0;
        m_fall[d][c] = 1'b0;
        if (reset) begin
          m_lvl[d][c]      = 1'b0;
          last_block[d][c] = edge_k;
        end else if (in_v[c] == m_lvl[d][c]) begin
          last_block[d][c] = edge_k;
        end else if (edge_k - last_block[d][c] >= s_of(d)) begin
          m_lvl[d][c]      = in_v[c];
          m_rise[d][c]     = in_v[c];
          m_fall[d][c]     = !in_v[c];
          last_block[d][c] = edge_k;
          m_any[d]         = 1'b1;
        end
      end
    end
    r2[0] = r1[0]; r2[1] = r1[1];
    r1[0] = a_raw; r1[1] = b_raw;
    rst2 = rst1; rst1 = reset;
    edge_k++;
    if (reset) model_valid = 1;
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model d%0d a_out", d),  dut_o[d][6], m_lvl[d][0]);
        check($sformatf("model d%0d b_out", d),  dut_o[d][5], m_lvl[d][1]);
        check($sformatf("model d%0d a_rise", d), dut_o[d][4], m_rise[d][0]);
        check($sformatf("model d%0d a_fall", d), dut_o[d][3], m_fall[d][0]);
        check($sformatf("model d%0d b_rise", d), dut_o[d][2], m_rise[d][1]);
        check($sformatf("model d%0d b_fall", d), dut_o[d][1], m_fall[d][1]);
        check($sformatf("model d%0d any", d),    dut_o[d][0], m_any[d]);
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus + literal expectations ----------------
  initial begin
    reset = 1'b1; a_raw = 1'b1; b_raw = 1'b1;

    // Reset with raws held high, then re-qualify after release.
    ticks(1);
    check("rst d0 outputs", |dut_o[0], 1'b0);
    check("rst d1 outputs", |dut_o[1], 1'b0);
    ticks(1);
    reset = 1'b0;
    ticks(2);
    check("s1 a_out edge1", a_out1, 1'b0);
    ticks(1);
    check("s1 a_out edge2", a_out1, 1'b1);
    check("s1 a_rise edge2", ar1, 1'b1);
    ticks(2);
    check("rel a_out edge4", a_out0, 1'b0);
    check("rel b_out edge4", b_out0, 1'b0);
    ticks(1);
    check("rel a_out edge5", a_out0, 1'b1);
    check("rel b_out edge5", b_out0, 1'b1);
    check("rel a_rise edge5", ar0, 1'b1);
    check("rel b_rise edge5", br0, 1'b1);
    check("rel any edge5", any0, 1'b1);
    ticks(1);
    check("rel a_rise edge6", ar0, 1'b0);
    check("rel any edge6", any0, 1'b0);
    check("rel a_out edge6", a_out0, 1'b1);

    // Qualified fall.
    a_raw = 1'b0;
    ticks(5);
    check("fall a_out edge4", a_out0, 1'b1);
    ticks(1);
    check("fall a_out edge5", a_out0, 1'b0);
    check("fall a_fall edge5", af0, 1'b1);
    check("fall any edge5", any0, 1'b1);
    ticks(1);
    check("fall a_fall edge6", af0, 1'b0);

    // Three-edge glitch is rejected.
    a_raw = 1'b1;
    ticks(3);
    a_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ticks(1);
      check("glitch a_out", a_out0, 1'b0);
      check("glitch a_rise", ar0, 1'b0);
    end

    // Simultaneous rise on both channels.
    b_raw = 1'b0;
    ticks(8);
    a_raw = 1'b1; b_raw = 1'b1;
    ticks(5);
    check("simul a_out edge4", a_out0, 1'b0);
    check("simul any edge4", any0, 1'b0);
    ticks(1);
    check("simul a_out edge5", a_out0, 1'b1);
    check("simul b_out edge5", b_out0, 1'b1);
    check("simul any edge5", any0, 1'b1);
    ticks(1);
    check("simul any edge6", any0, 1'b0);

    // Reset mid-count discards the partial count.
    a_raw = 1'b0;
    ticks(8);
    a_raw = 1'b1;
    ticks(3);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    ticks(2);
    check("midrst a_out edge5", a_out0, 1'b0);
    ticks(3);
    check("midrst a_out rel edge4", a_out0, 1'b0);
    ticks(1);
    check("midrst a_out rel edge5", a_out0, 1'b1);

    // Single-edge pulse propagates through the STABLE_CYCLES=1 build only.
    a_raw = 1'b0; b_raw = 1'b0;
    ticks(8);
    b_raw = 1'b1;
    ticks(1);
    b_raw = 1'b0;
    ticks(1);
    check("s1 pulse b_out edge1", b_out1, 1'b0);
    ticks(1);
    check("s1 pulse b_out edge2", b_out1, 1'b1);
    check("s1 pulse b_rise edge2", br1, 1'b1);
    check("s4 pulse b_out edge2", b_out0, 1'b0);
    ticks(1);
    check("s1 pulse b_out edge3", b_out1, 1'b0);
    check("s1 pulse b_fall edge3", bf1, 1'b1);
    check("s4 pulse b_rise edge3", br0, 1'b0);

    // Randomized phase: bursts of fast toggling mixed with long holds.
    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode = (i / 100) % 3;
      if (mode == 0) begin
        if ($urandom_range(0, 1) == 0) a_raw = ~a_raw;
        if ($urandom_range(0, 2) == 0) b_raw = ~b_raw;
      end else if (mode == 1) begin
        if ($urandom_range(0, 5) == 0) a_raw = ~a_raw;
        if ($urandom_range(0, 4) == 0) b_raw = ~b_raw;
      end else begin
        if ($urandom_range(0, 11) == 0) a_raw = ~a_raw;
        if ($urandom_range(0, 9) == 0) b_raw = ~b_raw;
      end
      reset = ($urandom_range(0, 199) == 0);
      ticks(1);
    end
    reset = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
